config_chain_loader: RTL and testbench

Configuration-memory loader that drives the `mem`/`mem_inv` select pairs of the transmission-gate routing and LUT multiplexer primitives. It accepts a bitstream as parallel words over a valid/ready handshake, then shifts the bits serially into a chain of `NUM_BITS` configuration flops. Once the chain is full it reports completion. It sits directly upstream of the multiplexer primitives, one instance per multiplexer memory group.

---
 rtl/config_chain_loader.sv | 127 ++++++++++++
 tb/tb_config_chain_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
// Bitstream loader: accepts parallel words over valid/ready and shifts them serially into a
// NUM_BITS configuration chain. Define CONFIG_SHADOW_EN to drive mem from a shadow register.
`timescale 1ns/1ps
module config_chain_loader #(
  parameter int NUM_BITS = 8,
  parameter int WORD_W   = 4
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                load_start,
  input  logic                bs_valid,
  input  logic [WORD_W-1:0]   bs_data,
  output logic                bs_ready,
  output logic [0:NUM_BITS-1] mem,
  output logic [0:NUM_BITS-1] mem_inv,
  output logic                ccff_tail,
  output logic                cfg_busy,
  output logic                cfg_done
);
  localparam int CNT_W = $clog2(NUM_BITS + 1);
  localparam int REM_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_reg, state_next;

  logic [CNT_W-1:0]    bits_left_reg;  // bits not yet shifted into the chain
  logic [CNT_W-1:0]    take_left_reg;  // bits not yet captured by the holding register
  logic [REM_W-1:0]    rem_reg;
  logic [WORD_W-1:0]   hold_reg;
  logic [0:NUM_BITS-1] chain_reg;
  logic [0:NUM_BITS-1] chain_next;
  logic                start;
  logic                shift_en;
  logic                last_shift;
  logic                handshake;
  logic [REM_W-1:0]    load_amt;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    bs_ready   = 1'b0;
    shift_en   = 1'b0;
    last_shift = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (load_start) begin
          start      = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // Ready while the last held bit is shifting so words stream at one bit per cycle.
        bs_ready   = (rem_reg <= REM_W'(1)) && (take_left_reg != '0);
        shift_en   = (rem_reg != '0);
        last_shift = shift_en && (bits_left_reg == CNT_W'(1));
        if (last_shift) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign handshake = bs_valid && bs_ready;

  always_comb begin
    if (32'(take_left_reg) >= WORD_W) load_amt = REM_W'(WORD_W);
    else                              load_amt = REM_W'(take_left_reg);
  end

  assign chain_next[0] = shift_en ? hold_reg[0] : chain_reg[0];
  generate
    for (genvar gi = 1; gi < NUM_BITS; gi++) begin : g_chain
      assign chain_next[gi] = shift_en ? chain_reg[gi-1] : chain_reg[gi];
    end
  endgenerate

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      chain_reg     <= '0;
      hold_reg      <= '0;
      rem_reg       <= '0;
      bits_left_reg <= '0;
      take_left_reg <= '0;
    end else begin
      chain_reg <= chain_next;
      if (start) begin
        rem_reg       <= '0;
        bits_left_reg <= CNT_W'(NUM_BITS);
        take_left_reg <= CNT_W'(NUM_BITS);
      end else begin
        if (handshake) begin
          hold_reg      <= bs_data;
          rem_reg       <= load_amt;
          take_left_reg <= take_left_reg - CNT_W'(load_amt);
        end else if (shift_en) begin
          hold_reg <= hold_reg >> 1;
          rem_reg  <= rem_reg - REM_W'(1);
        end
        if (shift_en) bits_left_reg <= bits_left_reg - CNT_W'(1);
      end
    end
  end

`ifdef CONFIG_SHADOW_EN
  logic [0:NUM_BITS-1] shadow_reg;

  // Capture the post-shift chain so mem jumps straight to the final configuration.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset)          shadow_reg <= '0;
    else if (last_shift) shadow_reg <= chain_next;
  end

  assign mem = shadow_reg;
`else
  assign mem = chain_reg;
`endif

  assign mem_inv   = ~mem;
  assign ccff_tail = chain_reg[NUM_BITS-1];
  assign cfg_busy  = (state_reg == SHIFT);
  assign cfg_done  = (state_reg == DONE);

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: an 8-bit/4-bit instance driven from a vector table
// plus a 6-bit instance for the partial-last-word sequence.
`timescale 1ns/1ps
module tb_config_chain_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       load_start = 1'b0, bs_valid = 1'b0;
  logic [3:0] bs_data = 4'h0;
  logic       bs_ready, ccff_tail, cfg_busy, cfg_done;
  logic [0:7] mem, mem_inv;

  logic       p_load_start = 1'b0, p_valid = 1'b0;
  logic [3:0] p_data = 4'h0;
  logic       p_ready, p_tail, p_busy, p_done;
  logic [0:5] p_mem, p_mem_inv;

  config_chain_loader #(.NUM_BITS(8), .WORD_W(4)) dut (
    .prog_clk(clk), .pReset(rst), .load_start(load_start), .bs_valid(bs_valid),
    .bs_data(bs_data), .bs_ready(bs_ready), .mem(mem), .mem_inv(mem_inv),
    .ccff_tail(ccff_tail), .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );

  config_chain_loader #(.NUM_BITS(6), .WORD_W(4)) dut6 (
    .prog_clk(clk), .pReset(rst), .load_start(p_load_start), .bs_valid(p_valid),
    .bs_data(p_data), .bs_ready(p_ready), .mem(p_mem), .mem_inv(p_mem_inv),
    .ccff_tail(p_tail), .cfg_busy(p_busy), .cfg_done(p_done)
  );

  typedef struct {
    logic [3:0] w0;
    logic [3:0] w1;
    int         stall;
    logic [0:7] exp_mem;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start a load, stream two words (optionally withholding the second for `stall` ready cycles),
  // and report edges from the first accept until cfg_done is seen.
  task automatic run_load(input logic [3:0] w0, input logic [3:0] w1, input int stall,
                          output int lat, output logic nz_busy, output int tog0);
    int   n_acc, stall_left, edges, budget;
    logic go, prev0;
    n_acc = 0; stall_left = stall; edges = 0; lat = -1; budget = 0;
    nz_busy = 1'b0; tog0 = 0;
    @(negedge clk); load_start = 1'b1; bs_valid = 1'b0;
    @(negedge clk); load_start = 1'b0; bs_data = w0; bs_valid = 1'b1;
    prev0 = mem[0];
    while (lat < 0 && budget < 60) begin
      go = bs_valid && bs_ready;
      if (n_acc == 1 && bs_ready && !bs_valid) stall_left--;
      @(posedge clk);
      if (n_acc > 0) edges++;
      @(negedge clk);
      budget++;
      if (go) begin
        n_acc++;
        bs_data = w1;
      end
      bs_valid = (n_acc == 0) || (n_acc == 1 && stall_left == 0);
      if (cfg_busy) begin
        if (mem != 8'h00) nz_busy = 1'b1;
        if (mem[0] != prev0) tog0++;
        prev0 = mem[0];
      end
      if (cfg_done) lat = edges;
    end
    bs_valid = 1'b0;
  endtask

  initial begin
    int         lat, tog0, edges, budget, n_acc;
    logic       nz, go;
    logic [0:7] exp_inv;

    vecs[0] = '{w0: 4'h5, w1: 4'hA, stall: 0, exp_mem: 8'b10100101, exp_lat: 8};
    vecs[1] = '{w0: 4'h5, w1: 4'hA, stall: 3, exp_mem: 8'b10100101, exp_lat: 11};
    vecs[2] = '{w0: 4'hA, w1: 4'h5, stall: 0, exp_mem: 8'b01011010, exp_lat: 8};
    vecs[3] = '{w0: 4'hF, w1: 4'h0, stall: 0, exp_mem: 8'b00001111, exp_lat: 8};
    vecs[4] = '{w0: 4'h1, w1: 4'h0, stall: 1, exp_mem: 8'b00000001, exp_lat: 9};

    // Reset before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_mem", 32'(mem), 32'h00);
    check("rst_mem_inv", 32'(mem_inv), 32'hFF);
    check("rst_ready", 32'(bs_ready), 32'h0);
    check("rst_done", 32'(cfg_done), 32'h0);
    check("rst_busy", 32'(cfg_busy), 32'h0);
    check("rst_tail", 32'(ccff_tail), 32'h0);
    check("rst_p_mem_inv", 32'(p_mem_inv), 32'h3F);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(bs_ready), 32'h0);

    // Load over the all-zero configuration, watching mem during SHIFT.
    run_load(4'h5, 4'hA, 0, lat, nz, tog0);
    $display("shadow-watch load: mem %b done after %0d edges, mem[0] toggles %0d", mem, lat, tog0);
    check("first_load_mem", 32'(mem), 32'(8'b10100101));
    check("first_load_lat", 32'(lat), 32'd8);
`ifdef CONFIG_SHADOW_EN
    check("shadow_mem_held_during_shift", 32'(nz), 32'h0);
`else
    check("ripple_mem0_toggles", 32'(tog0 > 0), 32'h1);
`endif

    for (int i = 0; i < 5; i++) begin
      run_load(vecs[i].w0, vecs[i].w1, vecs[i].stall, lat, nz, tog0);
      $display("vec %0d: words %h,%h stall %0d -> mem %b done after %0d edges",
               i, vecs[i].w0, vecs[i].w1, vecs[i].stall, mem, lat);
      exp_inv = ~vecs[i].exp_mem;
      check($sformatf("vec%0d_mem", i), 32'(mem), 32'(vecs[i].exp_mem));
      check($sformatf("vec%0d_mem_inv", i), 32'(mem_inv), 32'(exp_inv));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_tail", i), 32'(ccff_tail), 32'(vecs[i].exp_mem[7]));
      check($sformatf("vec%0d_busy", i), 32'(cfg_busy), 32'h0);
    end

    // Partial last word on the 6-bit chain, with a load_start pulse mid-shift that must be ignored.
    n_acc = 0; edges = 0; lat = -1; budget = 0;
    @(negedge clk); p_load_start = 1'b1;
    @(negedge clk); p_load_start = 1'b0; p_data = 4'hF; p_valid = 1'b1;
    while (lat < 0 && budget < 40) begin
      go = p_valid && p_ready;
      @(posedge clk);
      if (n_acc > 0) edges++;
      @(negedge clk);
      budget++;
      p_load_start = (n_acc == 1 && edges == 1);
      if (go) begin
        n_acc++;
        p_data = 4'hE;
        if (n_acc == 2) begin
          p_valid = 1'b0;
          check("partial_ready_after_last", 32'(p_ready), 32'h0);
        end
      end
      if (p_done) lat = edges;
    end
    $display("partial: words F,E -> mem %b done after %0d edges", p_mem, lat);
    check("partial_mem", 32'(p_mem), 32'(6'b101111));
    check("partial_mem_inv", 32'(p_mem_inv), 32'(6'b010000));
    check("partial_lat", 32'(lat), 32'd6);
    check("partial_tail", 32'(p_tail), 32'h1);

    // Words offered in DONE are not accepted.
    p_data = 4'h0; p_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("done_ready_low", 32'(p_ready), 32'h0);
    end
    p_valid = 1'b0;
    check("done_mem_kept", 32'(p_mem), 32'(6'b101111));
    check("done_held", 32'(p_done), 32'h1);

    // Abort after three shifted bits, then reload.
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0; bs_data = 4'hF; bs_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); bs_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("abort_busy_before", 32'(cfg_busy), 32'h1);
    rst = 1'b1;
    #1;
    $display("abort: mem %b mem_inv %b busy %b", mem, mem_inv, cfg_busy);
    check("abort_mem", 32'(mem), 32'h00);
    check("abort_mem_inv", 32'(mem_inv), 32'hFF);
    check("abort_busy", 32'(cfg_busy), 32'h0);
    check("abort_ready", 32'(bs_ready), 32'h0);
    check("abort_tail", 32'(ccff_tail), 32'h0);
    @(negedge clk); rst = 1'b0;
    run_load(4'hA, 4'h5, 0, lat, nz, tog0);
    $display("reload: words A,5 -> mem %b done after %0d edges", mem, lat);
    check("reload_mem", 32'(mem), 32'(8'b01011010));
    check("reload_lat", 32'(lat), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
